// File: rtl/instr_encoder_if.sv
// Request and IMEM write-port bundle between the program loader and instr_encoder.
// The master drives field-level requests; the slave (the encoder) drives the write port.
interface instr_encoder_if #(
    parameter int ADDR_W = 9
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_fmt;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;

    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;

    modport master (
        output req_valid, req_fmt, rd, rs1, rs2, funct3, funct7, imm,
        input  req_ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        input  req_valid, req_fmt, rd, rs1, rs2, funct3, funct7, imm,
        output req_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/instr_encoder.sv
// Encodes field-level RV32I requests into 32-bit instruction words and writes them
// to consecutive IMEM word addresses, with a full flag and a sticky range/format error.
module instr_encoder #(
    parameter int ADDR_W    = 9,
    parameter int BASE_ADDR = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    instr_encoder_if.slave        bus,
    output logic                  full,
    output logic                  err
);

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_IMM  = 3'd1,
        FMT_LW   = 3'd2,
        FMT_SW   = 3'd3,
        FMT_BR   = 3'd4,
        FMT_JAL  = 3'd5,
        FMT_JALR = 3'd6,
        FMT_ILL  = 3'd7
    } fmt_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] LAST = '1;

    fmt_e              fmt;
    logic [31:0]       imm;
    logic              fits12;
    logic              fits13;
    logic              fits21;
    logic [31:0]       enc_word;
    logic              enc_ok;
    logic              accept;

    logic [ADDR_W-1:0] addr;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [31:0]       wr_data_q;

    assign fmt = fmt_e'(bus.req_fmt);
    assign imm = bus.imm;

    // An immediate fits N signed bits when every bit above N-1 copies the sign bit.
    assign fits12 = (imm[31:11] == {21{imm[11]}});
    assign fits13 = (imm[31:12] == {20{imm[12]}});
    assign fits21 = (imm[31:20] == {12{imm[20]}});

    assign bus.req_ready = !full && !start;
    assign accept        = bus.req_valid && bus.req_ready;

    // NOTE: every output of a combinational block gets a default first so that no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        enc_word = '0;
        enc_ok   = 1'b0;
        case (fmt)
            FMT_R: begin
                enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, OP_R};
                enc_ok   = 1'b1;
            end
            FMT_IMM: begin
                enc_word = {imm[11:0], bus.rs1, bus.funct3, bus.rd, OP_IMM};
                enc_ok   = fits12;
            end
            FMT_LW: begin
                enc_word = {imm[11:0], bus.rs1, 3'b010, bus.rd, OP_LW};
                enc_ok   = fits12;
            end
            FMT_SW: begin
                enc_word = {imm[11:5], bus.rs2, bus.rs1, 3'b010, imm[4:0], OP_SW};
                enc_ok   = fits12;
            end
            FMT_BR: begin
                enc_word = {imm[12], imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                            imm[4:1], imm[11], OP_BR};
                enc_ok   = fits13 && !imm[0];
            end
            FMT_JAL: begin
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, OP_JAL};
                enc_ok   = fits21 && !imm[0];
            end
            FMT_JALR: begin
                enc_word = {imm[11:0], bus.rs1, 3'b000, bus.rd, OP_JALR};
                enc_ok   = fits12;
            end
            default: begin
                enc_word = '0;
                enc_ok   = 1'b0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr      <= BASE;
            full      <= 1'b0;
            err       <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= BASE;
            wr_data_q <= '0;
        end else if (start) begin
            addr    <= BASE;
            full    <= 1'b0;
            err     <= 1'b0;
            wr_en_q <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            if (accept) begin
                if (enc_ok) begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= addr;
                    wr_data_q <= enc_word;
                    // The address parks on the last word instead of wrapping.
                    if (addr == LAST) begin
                        full <= 1'b1;
                    end else begin
                        addr <= addr + 1'b1;
                    end
                end else begin
                    err <= 1'b1;
                end
            end
        end
    end

    assign bus.wr_en   = wr_en_q;
    assign bus.wr_addr = wr_addr_q;
    assign bus.wr_data = wr_data_q;

endmodule
